// File: rtl/crc_dma_ctrl_pkg.sv
// rtl/crc_dma_ctrl_pkg.sv - register offsets, CRC peripheral map and FSM encoding
// shared by the CRC DMA controller and its register block.
package crc_dma_ctrl_pkg;

    localparam int REG_SRC    = 'h00;
    localparam int REG_LEN    = 'h04;
    localparam int REG_CTRL   = 'h08;
    localparam int REG_STATUS = 'h0C;
    localparam int REG_RESULT = 'h10;

    localparam int CRC_DATA_ADDR   = 'h1000;
    localparam int CRC_CTRL_ADDR   = 'h1008;
    localparam int CRC_STATUS_ADDR = 'h100C;
    localparam int CRC_RESULT_ADDR = 'h1010;

    localparam logic [1:0] DATATYPE_WORD = 2'd2;

    typedef enum logic [3:0] {
        IDLE, SEED, ARM, FETCH, MWAIT, FEED, POLL, CHECK, NEXT, RES, RWAIT, FIN
    } state_t;

    // cont=0 reseeds the peripheral to all-ones, cont=1 keeps accumulating
    function automatic logic [31:0] crc_ctrl_word(input logic cont);
        return {29'b0, DATATYPE_WORD, cont};
    endfunction

endpackage

// File: rtl/crc_dma_ctrl_regs.sv
// rtl/crc_dma_ctrl_regs.sv - CPU register file and registered read mux
// for the CRC DMA controller (module crc_dma_regs).
module crc_dma_regs
    import crc_dma_ctrl_pkg::*;
#(
    parameter int MEM_AW = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [MEM_AW-1:0] cfg_r_addr_i,
    input  logic [MEM_AW-1:0] cfg_w_addr_i,
    input  logic [31:0]       cfg_data_i,
    input  logic              cfg_r_enable_i,
    input  logic              cfg_w_enable_i,
    output logic [31:0]       cfg_data_o,
    input  logic              busy_i,
    input  logic              set_done_i,
    input  logic              set_err_i,
    input  logic              result_we_i,
    input  logic [31:0]       result_i,
    output logic [MEM_AW-1:0] src_o,
    output logic [15:0]       len_o,
    output logic              start_o,
    output logic              abort_o,
    output logic              done_o,
    output logic              err_o
);
    logic [MEM_AW-1:0] src_q, src_d;
    logic [15:0]       len_q, len_d;
    logic [31:0]       result_q, result_d;
    logic [31:0]       cfg_data_q, cfg_data_d;
    logic              done_q, done_d, err_q, err_d;
    logic              wr_ctrl, rd_status;

    always_comb begin
        src_d      = src_q;
        len_d      = len_q;
        result_d   = result_q;
        done_d     = done_q;
        err_d      = err_q;
        cfg_data_d = '0;
        wr_ctrl    = cfg_w_enable_i && (cfg_w_addr_i == MEM_AW'(REG_CTRL));
        rd_status  = cfg_r_enable_i && (cfg_r_addr_i == MEM_AW'(REG_STATUS));

        if (cfg_w_enable_i && !busy_i && cfg_w_addr_i == MEM_AW'(REG_SRC))
            src_d = MEM_AW'(cfg_data_i) & ~MEM_AW'(3);
        if (cfg_w_enable_i && !busy_i && cfg_w_addr_i == MEM_AW'(REG_LEN))
            len_d = cfg_data_i[15:0];
        if (result_we_i)
            result_d = result_i;

        // a set arriving with the clearing STATUS read wins
        if (rd_status) begin
            done_d = 1'b0;
            err_d  = 1'b0;
        end
        if (set_done_i) done_d = 1'b1;
        if (set_err_i)  err_d  = 1'b1;

        if (cfg_r_enable_i) begin
            if (cfg_r_addr_i == MEM_AW'(REG_SRC))
                cfg_data_d = 32'(src_q);
            else if (cfg_r_addr_i == MEM_AW'(REG_LEN))
                cfg_data_d = {16'b0, len_q};
            else if (cfg_r_addr_i == MEM_AW'(REG_STATUS))
                cfg_data_d = {29'b0, err_q, done_q, busy_i};
            else if (cfg_r_addr_i == MEM_AW'(REG_RESULT))
                cfg_data_d = result_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            src_q      <= '0;
            len_q      <= '0;
            result_q   <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            cfg_data_q <= '0;
        end else begin
            src_q      <= src_d;
            len_q      <= len_d;
            result_q   <= result_d;
            done_q     <= done_d;
            err_q      <= err_d;
            cfg_data_q <= cfg_data_d;
        end
    end

    assign start_o    = wr_ctrl && cfg_data_i[0] && !busy_i;
    assign abort_o    = wr_ctrl && cfg_data_i[1];
    assign src_o      = src_q;
    assign len_o      = len_q;
    assign done_o     = done_q;
    assign err_o      = err_q;
    assign cfg_data_o = cfg_data_q;

endmodule

// File: rtl/crc_dma_ctrl.sv
// rtl/crc_dma_ctrl.sv - DMA engine feeding memory words into a CRC peripheral
// and collecting the result; FSM and all bus drivers live here.
module crc_dma_ctrl
    import crc_dma_ctrl_pkg::*;
#(
    parameter int MEM_AW   = 32,
    parameter int POLL_MAX = 63
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [MEM_AW-1:0] cfg_r_addr_i,
    input  logic [MEM_AW-1:0] cfg_w_addr_i,
    input  logic [31:0]       cfg_data_i,
    input  logic              cfg_r_enable_i,
    input  logic              cfg_w_enable_i,
    output logic [31:0]       cfg_data_o,
    output logic [MEM_AW-1:0] mem_addr_o,
    output logic              mem_r_enable_o,
    input  logic [31:0]       mem_data_i,
    output logic [MEM_AW-1:0] crc_r_addr_o,
    output logic [MEM_AW-1:0] crc_w_addr_o,
    output logic              crc_r_enable_o,
    output logic              crc_w_enable_o,
    output logic [31:0]       crc_wdata_o,
    input  logic [31:0]       crc_rdata_i,
    output logic              irq_o
);
    localparam int PCW = $clog2(POLL_MAX + 2);

    state_t            state_q, state_d;
    logic [MEM_AW-1:0] ptr_q, ptr_d, src;
    logic [15:0]       cnt_q, cnt_d, len;
    logic [31:0]       word_q, word_d;
    logic [PCW-1:0]    poll_q, poll_d;
    logic              busy_q, busy_d, fail_q, fail_d;
    logic              start, abort, done, err;
    logic              set_done, set_err, result_we;

    crc_dma_regs #(.MEM_AW(MEM_AW)) u_regs (
        .clk            (clk),
        .rst            (rst),
        .cfg_r_addr_i   (cfg_r_addr_i),
        .cfg_w_addr_i   (cfg_w_addr_i),
        .cfg_data_i     (cfg_data_i),
        .cfg_r_enable_i (cfg_r_enable_i),
        .cfg_w_enable_i (cfg_w_enable_i),
        .cfg_data_o     (cfg_data_o),
        .busy_i         (busy_q),
        .set_done_i     (set_done),
        .set_err_i      (set_err),
        .result_we_i    (result_we),
        .result_i       (crc_rdata_i),
        .src_o          (src),
        .len_o          (len),
        .start_o        (start),
        .abort_o        (abort),
        .done_o         (done),
        .err_o          (err)
    );

    always_comb begin
        state_d        = state_q;
        ptr_d          = ptr_q;
        cnt_d          = cnt_q;
        word_d         = word_q;
        poll_d         = poll_q;
        busy_d         = busy_q;
        fail_d         = fail_q;
        set_done       = 1'b0;
        set_err        = 1'b0;
        result_we      = 1'b0;
        mem_addr_o     = '0;
        mem_r_enable_o = 1'b0;
        crc_r_addr_o   = '0;
        crc_w_addr_o   = '0;
        crc_r_enable_o = 1'b0;
        crc_w_enable_o = 1'b0;
        crc_wdata_o    = '0;

        case (state_q)
            IDLE: if (start) begin
                if (len == 16'd0) begin
                    set_done = 1'b1;
                end else begin
                    ptr_d   = src;
                    cnt_d   = len;
                    busy_d  = 1'b1;
                    fail_d  = 1'b0;
                    state_d = SEED;
                end
            end
            SEED: begin
                crc_w_enable_o = 1'b1;
                crc_w_addr_o   = MEM_AW'(CRC_CTRL_ADDR);
                crc_wdata_o    = crc_ctrl_word(1'b0);
                state_d        = ARM;
            end
            ARM: begin
                crc_w_enable_o = 1'b1;
                crc_w_addr_o   = MEM_AW'(CRC_CTRL_ADDR);
                crc_wdata_o    = crc_ctrl_word(1'b1);
                state_d        = FETCH;
            end
            FETCH: begin
                mem_r_enable_o = 1'b1;
                mem_addr_o     = ptr_q;
                state_d        = MWAIT;
            end
            MWAIT: begin
                word_d  = mem_data_i;
                state_d = FEED;
            end
            FEED: begin
                crc_w_enable_o = 1'b1;
                crc_w_addr_o   = MEM_AW'(CRC_DATA_ADDR);
                crc_wdata_o    = word_q;
                poll_d         = '0;
                state_d        = POLL;
            end
            POLL: begin
                crc_r_enable_o = 1'b1;
                crc_r_addr_o   = MEM_AW'(CRC_STATUS_ADDR);
                state_d        = CHECK;
            end
            CHECK: begin
                // poll_q counts failed polls so far; one more failure past POLL_MAX is fatal
                if (crc_rdata_i[0]) begin
                    state_d = NEXT;
                end else if (poll_q == PCW'(POLL_MAX)) begin
                    set_err = 1'b1;
                    fail_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = FIN;
                end else begin
                    poll_d  = poll_q + PCW'(1);
                    state_d = POLL;
                end
            end
            NEXT: begin
                ptr_d   = ptr_q + MEM_AW'(4);
                cnt_d   = cnt_q - 16'd1;
                state_d = (cnt_q != 16'd1) ? FETCH : RES;
            end
            RES: begin
                crc_r_enable_o = 1'b1;
                crc_r_addr_o   = MEM_AW'(CRC_RESULT_ADDR);
                state_d        = RWAIT;
            end
            RWAIT: begin
                result_we = 1'b1;
                state_d   = FIN;
            end
            FIN: begin
                crc_w_enable_o = 1'b1;
                crc_w_addr_o   = MEM_AW'(CRC_CTRL_ADDR);
                crc_wdata_o    = crc_ctrl_word(1'b0);
                busy_d         = 1'b0;
                set_done       = !fail_q;
                state_d        = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (abort && state_q != IDLE && state_q != FIN) begin
            state_d   = FIN;
            set_err   = 1'b1;
            set_done  = 1'b0;
            result_we = 1'b0;
            fail_d    = 1'b1;
            busy_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            word_q  <= '0;
            poll_q  <= '0;
            busy_q  <= 1'b0;
            fail_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
            poll_q  <= poll_d;
            busy_q  <= busy_d;
            fail_q  <= fail_d;
        end
    end

    assign irq_o = done | err;

endmodule

// File: doc/crc_dma_ctrl.md
CRC_DMA_CTRL -- requirements
Module: crc_dma_ctrl

Interface
REQ-001 SHALL have parameter MEM_AW, default 32: width of the memory and register address buses.
REQ-002 SHALL have parameter POLL_MAX, default 63: the maximum number of status polls per word before an error is flagged.
REQ-003 SHALL have the following ports (clock and reset first):
- clk  in  1  single clock, all state on posedge.
- rst  in  1  asynchronous, active-high reset.
- cfg_r_addr_i, cfg_w_addr_i  in  MEM_AW  CPU register read/write addresses.
- cfg_data_i  in  32  CPU write data.
- cfg_r_enable_i, cfg_w_enable_i  in  1  CPU read/write strobes.
- cfg_data_o  out  32  registered CPU read data.
- mem_addr_o  out  MEM_AW  memory read address.
- mem_r_enable_o  out  1  memory read strobe.
- mem_data_i  in  32  memory data, valid one cycle after the strobe.
- crc_r_addr_o, crc_w_addr_o  out  MEM_AW  CRC peripheral read/write addresses.
- crc_r_enable_o, crc_w_enable_o  out  1  CRC read/write strobes.
- crc_wdata_o  out  32  CRC write data.
- crc_rdata_i  in  32  CRC read data, valid one cycle after the read.
- irq_o  out  1  level interrupt, high while done or err is set.

Function
REQ-004 SHALL decode the following registers: 0x00 SRC (word-aligned start address), 0x04 LEN (16-bit word count), 0x08 CTRL (bit0 start, bit1 abort; both self-clearing, read back as 0), 0x0C STATUS (bit0 busy, bit1 done, bit2 err), 0x10 RESULT.
REQ-005 SHALL return cfg_data_o one cycle after the read address; unmapped addresses return 0.
REQ-006 SHALL clear done and err on a STATUS read; a set on the same cycle takes priority.
REQ-007 SHALL ignore writes to SRC, LEN and CTRL.start while busy; CTRL.abort is honoured in any state.
REQ-008 SHALL implement an FSM with states IDLE, SEED, ARM, FETCH, MWAIT, FEED, POLL, CHECK, NEXT, RES, RWAIT, FIN.
REQ-009 IDLE: on start with LEN=0, SHALL set done the next cycle with no bus activity and leave RESULT unchanged; on start with LEN>0, SHALL latch SRC into the address pointer and LEN into the remaining count, set busy, and go to SEED.
REQ-010 SEED: SHALL write CRC ctrl = (`datatype_word<<1)|0, so the seed resets to 0xFFFFFFFF; ARM: SHALL write CRC ctrl = (`datatype_word<<1)|1 (continue).
REQ-011 FETCH: SHALL assert mem_r_enable_o for one cycle at the pointer; MWAIT: SHALL capture mem_data_i.
REQ-012 FEED: SHALL write the captured word to `crc_data_addr for exactly one cycle.
REQ-013 POLL/CHECK: SHALL issue one read of `crc_status_addr, then sample bit0 of crc_rdata_i the next cycle.
- If the bit is 1, go to NEXT.
- Otherwise increment the poll counter and return to POLL.
- If the counter exceeds POLL_MAX, set err, clear busy and go to FIN.
REQ-014 NEXT: SHALL add 4 to the pointer (wrapping modulo 2^MEM_AW) and decrement the count; go to FETCH if the count is nonzero, else RES.
REQ-015 RES/RWAIT: SHALL read `crc_result_addr and latch crc_rdata_i into RESULT.
REQ-016 FIN: SHALL write CRC ctrl with continue=0, clear busy, set done unless err, and return to IDLE.
REQ-017 Abort SHALL force FIN on the next cycle from any busy state: done=0, err=1, RESULT unchanged, and no further memory or CRC data writes.
REQ-018 Strobes SHALL be one-hot per cycle: at most one of mem_r_enable_o, crc_w_enable_o, crc_r_enable_o high.
REQ-019 The poll counter SHALL reset to 0 on every FEED.

Reset
REQ-020 On rst high, all state SHALL clear asynchronously: FSM to IDLE, SRC/LEN/RESULT/pointer/count to 0, busy/done/err to 0, all strobes and outputs to 0, cfg_data_o to 0.
REQ-021 Reset asserted mid-transfer SHALL abandon the transfer without any further bus strobe.

Structure
REQ-022 Register offsets, the FSM state encoding and the CRC register addresses (`crc_*_addr, `datatype_word) SHALL live in the shared define file.
REQ-023 The CPU register file and read mux SHALL be a sub-module, crc_dma_regs; the FSM and bus drivers SHALL stay in crc_dma_ctrl.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- SRC=0x100, LEN=1, mem[0x100]=0xFFFFFFFF, CRC model attached -> RESULT=0x00000000, done=1, irq_o=1, exactly one CRC data write.
- LEN=4, words 0x01020304..0x0D0E0F10 -> RESULT equals the MPEG-2 (poly 0x04C11DB7, init 0xFFFFFFFF, MSB-first) model; mem addresses 0x100, 0x104, 0x108, 0x10C in order.
- LEN=0 start -> done=1 after one cycle, no mem/CRC strobes.
- CRC model never sets complete -> err=1 after 64 polls, busy=0, done=0.
- Abort written during the third word's POLL -> err=1 next cycle, FIN ctrl write issued, RESULT unchanged; a STATUS read then clears err and drops irq_o.
- rst pulsed during FEED -> all outputs 0 immediately; a new start with LEN=1 then completes correctly.
